fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the loop/branch FSM (simpleFSM). It owns the PC and issues in-order requests to instruction memory. Returned words are buffered in a small prefetch FIFO and presented to the FSM one per cycle as curr_PC, instruction and immediate. It honours the FSM's block_signal (stall) and its flush/new_pc redirect.

---
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests and feeds the loop/branch FSM
// through a prefetch FIFO. Optional FETCH_PERF_EN adds fetched/bubble performance counters.
module fetch_stage #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        block_signal,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic [31:0] curr_PC,
  output logic [31:0] instruction,
  output logic [31:0] immediate,
  output logic        out_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc, resp_pc;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];

  logic [CW:0] in_use;
  logic        accept, resp_ok, dropping, push, pop, bubble;
  logic [31:0] pop_word;

  function automatic logic [31:0] decode_imm(input logic [31:0] i);
    case (i[6:0])
      7'b1100011:                         return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b1101111:                         return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      7'b0010011, 7'b0000011, 7'b1100111: return {{20{i[31]}}, i[31:20]};
      default:                            return 32'h0;
    endcase
  endfunction

  // Credits cover both in-flight requests and buffered words, so the FIFO can never overflow.
  always_comb begin
    in_use    = (CW+1)'(outstanding) + (CW+1)'(fifo_count);
    imem_req  = reset & ~flush & (in_use < DEPTH_W);
    imem_addr = pc;
    accept    = imem_req & imem_gnt;
    resp_ok   = imem_rvalid & (outstanding != '0);
    dropping  = resp_ok & (drop_cnt != '0);
    push      = resp_ok & ~dropping & ~flush;
    pop       = ~flush & ~block_signal & (fifo_count != '0);
    bubble    = ~flush & ~block_signal & (fifo_count == '0);
    pop_word  = word_mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      case ({accept, resp_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (flush) begin
        pc       <= new_pc;
        resp_pc  <= new_pc;
        drop_cnt <= outstanding - CW'(resp_ok);
      end else begin
        if (accept)   pc       <= pc + 32'd4;
        if (push)     resp_pc  <= resp_pc + 32'd4;
        if (dropping) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      word_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Bubbles keep curr_PC so the FSM still sees where the stream stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curr_PC     <= '0;
      instruction <= '0;
      immediate   <= '0;
      out_valid   <= 1'b0;
    end else if (flush) begin
      curr_PC     <= '0;
      instruction <= '0;
      immediate   <= '0;
      out_valid   <= 1'b0;
    end else if (block_signal) begin
      curr_PC     <= curr_PC;
    end else if (pop) begin
      curr_PC     <= pc_mem[rd_ptr];
      instruction <= pop_word;
      immediate   <= decode_imm(pop_word);
      out_valid   <= 1'b1;
    end else begin
      instruction <= '0;
      immediate   <= '0;
      out_valid   <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop)    perf_fetched <= perf_fetched + 32'd1;
      if (bubble) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage: a queue-based reference model plus a latency-configurable memory.
module tb_fetch_stage;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        block_signal = 1'b0, flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic [31:0] curr_PC, instruction, immediate;
  logic        out_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .block_signal(block_signal), .flush(flush), .new_pc(new_pc),
    .curr_PC(curr_PC), .instruction(instruction), .immediate(immediate), .out_valid(out_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] word; } entry_t;
  typedef struct { int due; logic [31:0] addr; } mem_req_t;

  entry_t   m_fifo[$];
  mem_req_t mem_q[$];
  int vectors = 0, miscompares = 0, cyc = 0, lat = 1;
  bit hashed = 0, rand_resp = 0;

  // Reference model state: the architectural view of the fetch stage.
  logic [31:0] m_pc, m_rpc, m_cpc, m_ins, m_imm;
  logic        m_val;
  int          m_outst, m_drop;
  logic [31:0] m_pf, m_pb;

  // Observation helpers for hand-computed checks.
  logic        last_req;
  logic [31:0] last_addr;
  bit          got_first;
  logic [31:0] first_pc, first_ins, first_imm;
  logic [31:0] seen_imm [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_imm(input logic [31:0] i);
    logic [31:0] r;
    r = 32'h0;
    case (i & 32'h7F)
      32'h63: begin
        r = (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
        if (i[31]) r = r | 32'hFFFF_F000;
      end
      32'h6F: begin
        r = (((i >> 12) & 32'hFF) << 12) | (((i >> 20) & 32'h1) << 11) | (((i >> 21) & 32'h3FF) << 1);
        if (i[31]) r = r | 32'hFFF0_0000;
      end
      32'h13, 32'h03, 32'h67: r = $unsigned($signed(i) >>> 20);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] h;
    logic [6:0]  op;
    if (!hashed) begin
      case (addr)
        32'h10C: return 32'hFE00_1AE3;
        32'h110: return 32'hFF5F_F06F;
        32'h114: return 32'h0000_0016;
        default: return 32'h0000_0013;
      endcase
    end
    h = addr * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    case (h[2:0])
      3'd0: op = 7'h63; 3'd1: op = 7'h6F; 3'd2: op = 7'h13; 3'd3: op = 7'h03;
      3'd4: op = 7'h67; 3'd5: op = 7'h33; 3'd6: op = 7'h16; default: op = 7'h37;
    endcase
    return {h[31:7], op};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_rpc = RESET_PC;
    m_cpc = '0; m_ins = '0; m_imm = '0; m_val = 1'b0;
    m_outst = 0; m_drop = 0; m_pf = '0; m_pb = '0;
    m_fifo.delete();
    mem_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; flush = 1'b0; block_signal = 1'b0;
    #1;
    model_reset();
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_curr_PC", curr_PC, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_immediate", immediate, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One clock: apply inputs, check the combinational request, advance model, check registers.
  task automatic step(input bit g, input bit b, input bit f, input logic [31:0] np);
    bit     m_req, acc, resp, push;
    entry_t e;
    imem_gnt = g; block_signal = b; flush = f; new_pc = np;
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc && (!rand_resp || $urandom_range(3) != 0)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_q[0].addr);
      end
    end else if (rand_resp && $urandom_range(7) == 0) begin
      imem_rvalid = 1'b1;
    end
    #1;
    m_req = !f && (m_outst + m_fifo.size() < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    last_req = imem_req; last_addr = imem_addr;
    @(posedge clk);
    if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (last_req && g) mem_q.push_back('{due: cyc + lat, addr: last_addr});

    acc  = m_req && g;
    resp = imem_rvalid && (m_outst > 0);
    if (f) begin
      m_cpc = '0; m_ins = '0; m_imm = '0; m_val = 1'b0;
    end else if (!b) begin
      if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        m_cpc = e.pc; m_ins = e.word; m_imm = model_imm(e.word); m_val = 1'b1;
        m_pf = m_pf + 1;
      end else begin
        m_ins = '0; m_imm = '0; m_val = 1'b0;
        m_pb = m_pb + 1;
      end
    end
    push = !f && resp && (m_drop == 0);
    if (f) m_fifo.delete();
    else if (push) begin
      m_fifo.push_back('{pc: m_rpc, word: imem_rdata});
      m_rpc = m_rpc + 32'd4;
    end
    if (f) m_drop = m_outst - int'(resp);
    else if (resp && m_drop > 0) m_drop--;
    m_outst = m_outst + int'(acc) - int'(resp);
    if (f) begin m_pc = np; m_rpc = np; end
    else if (acc) m_pc = m_pc + 32'd4;
    cyc++;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_val});
    chk("curr_PC", curr_PC, m_cpc);
    chk("instruction", instruction, m_ins);
    chk("immediate", immediate, m_imm);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_pf);
    chk("perf_bubbles", perf_bubbles, m_pb);
`endif
    if (out_valid) begin
      seen_imm[curr_PC] = immediate;
      if (!got_first) begin
        got_first = 1; first_pc = curr_PC; first_ins = instruction; first_imm = immediate;
      end
    end
  endtask

  initial begin
    int req_cnt;
    logic [31:0] np;
    #1;
    // Straight-line fetch of NOPs and a few decoded immediates.
    do_reset(); lat = 1; got_first = 0;
    repeat (14) step(1, 0, 0, '0);
    chk("first_pc", got_first ? first_pc : 32'hDEAD_BEEF, 32'h100);
    chk("first_ins", got_first ? first_ins : 32'hDEAD_BEEF, 32'h13);
    chk("first_imm", got_first ? first_imm : 32'hDEAD_BEEF, 32'h0);
    chk("imm_bne", seen_imm.exists(32'h10C) ? seen_imm[32'h10C] : 32'hDEAD_BEEF, 32'hFFFF_FFF4);
    chk("imm_jal", seen_imm.exists(32'h110) ? seen_imm[32'h110] : 32'hDEAD_BEEF, 32'hFFFF_FFF4);
    chk("imm_other", seen_imm.exists(32'h114) ? seen_imm[32'h114] : 32'hDEAD_BEEF, 32'h0);

    // Stall from reset: credits cap the in-flight fetches at DEPTH.
    do_reset(); req_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 0, '0);
      if (last_req) req_cnt++;
    end
    chk("block_req_count", req_cnt, DEPTH);
    chk("block_req_low", {31'b0, last_req}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, '0);
      chk("release_pc", curr_PC, 32'h100 + 32'(4 * k));
      chk("release_valid", {31'b0, out_valid}, 32'h1);
    end

    // Slow memory, two requests in flight, then a redirect.
    do_reset(); lat = 3;
    step(1, 0, 0, '0); step(1, 0, 0, '0); step(0, 0, 0, '0);
    got_first = 0;
    step(1, 0, 1, 32'h110);
    repeat (12) step(1, 0, 0, '0);
    chk("redirect_pc", got_first ? first_pc : 32'hDEAD_BEEF, 32'h110);
    chk("redirect_ins", got_first ? first_ins : 32'hDEAD_BEEF, 32'hFF5F_F06F);

    // Flush colliding with a response while stalled.
    do_reset(); lat = 1;
    repeat (8) step(1, 0, 0, '0);
    step(1, 1, 1, 32'h200);
    chk("flush_req_low", {31'b0, last_req}, 32'h0);
    chk("flush_zero_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_zero_ins", instruction, 32'h0);
    step(1, 0, 0, '0);
    chk("post_flush_req", {31'b0, last_req}, 32'h1);
    chk("post_flush_addr", last_addr, 32'h200);

    // Reset in the middle of a full, stalled stream.
    do_reset();
    repeat (6) step(1, 0, 0, '0);
    repeat (8) step(1, 1, 0, '0);
    do_reset();
    step(1, 0, 0, '0);
    chk("restart_addr", last_addr, 32'h100);

    // Randomised traffic with irregular responses, stalls, redirects and resets.
    hashed = 1; rand_resp = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 0) begin
        do_reset();
        lat = $urandom_range(3, 1);
      end
      np = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(15) == 0, np);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
